mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register and writeback controller between the memory stage and the register file.
- Captures the memory-stage instruction, ALU result, load data, PC+1 and exception status code every enabled cycle.
- Decodes the captured instruction into register-file write controls: normal rd writes, lw data, jal link to $r31, setx and overflow status to $rstatus ($r30).
- Keeps a saturating count of committed exceptions for debug.

Parameters:
- STATUS_REG, 30, register index written on exception or setx.
- LINK_REG, 31, register index written by jal.
- CNT_W, 8, width of the exception counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = capture MEM-stage inputs; 0 = hold (stall).
- flush  in  1  1 = capture a bubble instead of the inputs.
- mem_insn  in  32  instruction in MEM stage.
- mem_pc_plus1  in  32  PC+1 of that instruction.
- mem_alu_result  in  32  ALU/address result.
- mem_data_read  in  32  dmem read data, valid at the capturing edge.
- mem_exception  in  1  overflow flag carried from execute.
- mem_exception_data  in  32  status code from memory stage: 1 add, 2 addi, 3 sub, 4 mul, 5 div, 0 none.
- ctrl_writeEnable  out  1  register-file write enable.
- ctrl_writeReg  out  5  register-file destination.
- data_writeReg  out  32  register-file write data.
- wb_insn  out  32  registered instruction, for bypass/hazard logic.
- wb_valid  out  1  1 = captured slot holds a real instruction (not a bubble or reset).
- exception_count  out  CNT_W  committed exceptions, saturating.

Behaviour:
- Reset (asynchronous, while reset=0):
  - All stage registers, wb_valid and exception_count are 0.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, wb_insn=0.
  - Takes effect immediately, including mid-stall; the held instruction is discarded.
- Capture on rising edge:
  - flush=1: load a bubble (insn=0, data=0, exception=0, wb_valid=0). flush has priority over enable, and a bubble is loaded even if enable=0.
  - flush=0, enable=1: load all mem_* inputs; wb_valid=1.
  - flush=0, enable=0: hold all registers unchanged.
- Outputs are combinational from the registered state only. Latency is 1 cycle from capture edge to write controls. No combinational path from mem_* inputs to outputs.
- Field decode: opcode=insn[31:27], rd=insn[26:22], aluop=insn[6:2], T=insn[26:0].
- Write selection, first match wins:
  1. Exception: wb_valid, exception=1, status code≠0 -> reg STATUS_REG, data = status code.
  2. setx (10101) -> reg STATUS_REG, data = T zero-extended to 32 bits.
  3. jal (00011) -> reg LINK_REG, data = pc_plus1.
  4. lw (01000) -> reg rd, data = mem_data_read.
  5. R-type (00000) or addi (00101) -> reg rd, data = alu_result.
  6. Otherwise (sw, j, bne, blt, jr, bex, unknown) -> ctrl_writeEnable=0.
- ctrl_writeEnable:
  - 1 only when wb_valid=1, a write is selected, and the selected register ≠ 0.
  - A write to $r0 is always suppressed. The all-zero nop therefore never writes.
- When ctrl_writeEnable=0, ctrl_writeReg and data_writeReg are driven 0 (no stale values).
- exception=1 with status code 0 (e.g. and/or overflow flag) is ignored; the instruction writes normally via rule 5.
- exception_count:
  - Increments by 1 on each capturing edge (flush=0, enable=1) whose inputs satisfy the rule-1 condition.
  - Saturates at 2^CNT_W−1; it never wraps.
  - Held during stall. Not affected by flush.
- A stall held for N cycles presents the same write for N cycles; the register file tolerates repeated identical writes.

Decomposition:
- Shared package (processor-wide definitions):
  - Opcode constants: RTYPE, J, BNE, JAL, JR, ADDI, BLT, SW, LW, SETX, BEX.
  - ALU op constants.
  - Status code constants 1–5.
  - Register indices for $r0, $rstatus, $ra.
- One sub-module: wb_select. It is purely combinational: registered fields in, writeEnable/writeReg/writeData out, implementing the priority list. The top level holds the pipeline registers and the counter.

Test Plan:
- Reset then release, enable=1, inject add $3,$1,$2 with alu_result=0x0000_0007 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=7; while reset=0 all outputs 0.
- lw $5 with mem_data_read=0xDEAD_BEEF, then sw -> lw cycle writes reg 5 with 0xDEADBEEF; sw cycle ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- add overflow (exception=1, code 1), then addi overflow (code 2), then exception=1 with aluop=AND (code 0) and rd=4 -> writes (30,1), (30,2), then (4,alu_result); exception_count ends at 2.
- jal with pc_plus1=0x40, then setx T=0x7FF_FFFF -> writes (31,0x40) then (30,0x07FFFFFF); insn add $0 with alu_result≠0 -> ctrl_writeEnable=0.
- Stall 3 cycles holding lw $6 with data 0x12, then flush while enable=0, then drop reset mid-stall -> (6,0x12) held for all 3 cycles; after flush wb_valid=0, wb_insn=0 and no write; asynchronous reset clears outputs before the next clock edge.
- Drive 260 consecutive code-3 exceptions -> exception_count reaches 255 and stays 255.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Processor-wide definitions shared by the MEM/WB stage: opcodes, ALU ops,
// overflow status codes and architectural register indices.
package mem_wb_stage_pkg;

    // Opcodes, insn[31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // ALU ops, insn[6:2] of R-type
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Overflow status codes written to $rstatus
    localparam logic [31:0] ST_NONE = 32'd0;
    localparam logic [31:0] ST_ADD  = 32'd1;
    localparam logic [31:0] ST_ADDI = 32'd2;
    localparam logic [31:0] ST_SUB  = 32'd3;
    localparam logic [31:0] ST_MUL  = 32'd4;
    localparam logic [31:0] ST_DIV  = 32'd5;

    // Architectural register indices
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_plus1;
        logic [31:0] alu_result;
        logic [31:0] data_read;
        logic        exception;
        logic [31:0] exception_data;
    } stage_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side capture inputs and writeback-side outputs of the MEM/WB stage.
interface mem_wb_stage_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             flush;
    logic [31:0]      mem_insn;
    logic [31:0]      mem_pc_plus1;
    logic [31:0]      mem_alu_result;
    logic [31:0]      mem_data_read;
    logic             mem_exception;
    logic [31:0]      mem_exception_data;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic [31:0]      wb_insn;
    logic             wb_valid;
    logic [CNT_W-1:0] exception_count;

    modport master (
        output enable, flush, mem_insn, mem_pc_plus1, mem_alu_result, mem_data_read,
               mem_exception, mem_exception_data,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_insn, wb_valid,
               exception_count
    );

    modport slave (
        input  enable, flush, mem_insn, mem_pc_plus1, mem_alu_result, mem_data_read,
               mem_exception, mem_exception_data,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, wb_insn, wb_valid,
               exception_count
    );
endinterface

// File: rtl/mem_wb_stage_wb_select.sv
// Combinational writeback decode: picks destination register and data for the
// registered instruction using a fixed priority list.
module mem_wb_stage_wb_select
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned STATUS_REG = 30,
    parameter int unsigned LINK_REG   = 31
) (
    input  logic        valid,
    input  logic [31:0] insn,
    input  logic [31:0] pc_plus1,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_read,
    input  logic        exception,
    input  logic [31:0] exception_data,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
);
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic        sel;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    assign opcode = insn[31:27];
    assign rd     = insn[26:22];

    // Priority selection: exception status, setx, jal, lw, ALU result
    always_comb begin
        sel      = 1'b1;
        sel_reg  = REG_ZERO;
        sel_data = '0;
        if (exception && exception_data != ST_NONE) begin
            sel_reg  = 5'(STATUS_REG);
            sel_data = exception_data;
        end else begin
            case (opcode)
                OP_SETX: begin
                    sel_reg  = 5'(STATUS_REG);
                    sel_data = {5'b0, insn[26:0]};
                end
                OP_JAL: begin
                    sel_reg  = 5'(LINK_REG);
                    sel_data = pc_plus1;
                end
                OP_LW: begin
                    sel_reg  = rd;
                    sel_data = data_read;
                end
                OP_RTYPE, OP_ADDI: begin
                    sel_reg  = rd;
                    sel_data = alu_result;
                end
                default: sel = 1'b0;
            endcase
        end
    end

    // Gate with valid and $r0 suppression; idle outputs are zero, never stale
    always_comb begin
        write_enable = valid && sel && (sel_reg != REG_ZERO);
        write_reg    = write_enable ? sel_reg : '0;
        write_data   = write_enable ? sel_data : '0;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback control decode and a saturating
// count of committed exceptions.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned STATUS_REG = 30,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned CNT_W      = 8
) (
    input logic           clock,
    input logic           reset,
    mem_wb_stage_if.slave bus
);
    stage_t           stage_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             exc_hit;

    // Only a non-zero status code counts as an exception
    assign exc_hit = bus.mem_exception && (bus.mem_exception_data != ST_NONE);

    // Pipeline register: flush beats enable, otherwise capture or hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            stage_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.enable) begin
            stage_q.insn           <= bus.mem_insn;
            stage_q.pc_plus1       <= bus.mem_pc_plus1;
            stage_q.alu_result     <= bus.mem_alu_result;
            stage_q.data_read      <= bus.mem_data_read;
            stage_q.exception      <= bus.mem_exception;
            stage_q.exception_data <= bus.mem_exception_data;
            valid_q                <= 1'b1;
        end
    end

    // Exception counter: counts captured exceptions and sticks at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (!bus.flush && bus.enable && exc_hit && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    mem_wb_stage_wb_select #(
        .STATUS_REG (STATUS_REG),
        .LINK_REG   (LINK_REG)
    ) u_wb_select (
        .valid          (valid_q),
        .insn           (stage_q.insn),
        .pc_plus1       (stage_q.pc_plus1),
        .alu_result     (stage_q.alu_result),
        .data_read      (stage_q.data_read),
        .exception      (stage_q.exception),
        .exception_data (stage_q.exception_data),
        .write_enable   (bus.ctrl_writeEnable),
        .write_reg      (bus.ctrl_writeReg),
        .write_data     (bus.data_writeReg)
    );

    assign bus.wb_insn         = stage_q.insn;
    assign bus.wb_valid        = valid_q;
    assign bus.exception_count = count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic, compared against a transaction-level model of the stage.
module tb_mem_wb_stage;
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exc;
        logic [31:0] code;
    } txn_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    // Model state: last captured transaction, whether it is real, counter
    txn_t       slot;
    logic       slot_valid;
    logic [7:0] cnt;

    mem_wb_stage_if #(.CNT_W(8)) bus ();

    mem_wb_stage #(
        .STATUS_REG (30),
        .LINK_REG   (31),
        .CNT_W      (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] r_insn(input logic [4:0] rd, input logic [4:0] aluop);
        return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 5'd1, 17'h00010};
    endfunction

    function automatic txn_t mk(input logic [31:0] insn, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input logic exc, input logic [31:0] code);
        txn_t t;
        t.insn = insn; t.pc = pc; t.alu = alu; t.rdata = rdata; t.exc = exc; t.code = code;
        return t;
    endfunction

    // Expected outputs from the model: {we, reg, data, wb_insn, wb_valid, count}
    function automatic logic [78:0] model_vec();
        logic [4:0]  op;
        logic [4:0]  r;
        logic [31:0] d;
        logic        wr;
        logic        we;
        op = slot.insn[31:27];
        wr = 1'b1;
        r  = 5'd0;
        d  = 32'd0;
        if (slot.exc && slot.code != 0) begin
            r = 5'd30; d = slot.code;
        end else if (op == 5'b10101) begin
            r = 5'd30; d = {5'b0, slot.insn[26:0]};
        end else if (op == 5'b00011) begin
            r = 5'd31; d = slot.pc;
        end else if (op == 5'b01000) begin
            r = slot.insn[26:22]; d = slot.rdata;
        end else if (op == 5'b00000 || op == 5'b00101) begin
            r = slot.insn[26:22]; d = slot.alu;
        end else begin
            wr = 1'b0;
        end
        we = slot_valid && wr && (r != 5'd0);
        if (!we) begin
            r = 5'd0; d = 32'd0;
        end
        return {we, r, d, slot.insn, slot_valid, cnt};
    endfunction

    function automatic logic [78:0] dut_vec();
        return {bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.wb_insn,
                bus.wb_valid, bus.exception_count};
    endfunction

    function automatic txn_t rand_txn();
        logic [4:0]  ops [12];
        logic [31:0] raw;
        txn_t        t;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                5'b00110, 5'b00111, 5'b01000, 5'b10101, 5'b10110, 5'b11111};
        raw    = $urandom();
        t.insn = {ops[$urandom_range(0, 11)], raw[26:0]};
        t.pc   = $urandom();
        t.alu  = $urandom();
        t.rdata = $urandom();
        t.exc  = ($urandom_range(0, 3) == 0);
        t.code = 32'($urandom_range(0, 5));
        return t;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle
    task automatic cycle(input logic en, input logic fl, input txn_t t);
        bus.enable             = en;
        bus.flush              = fl;
        bus.mem_insn           = t.insn;
        bus.mem_pc_plus1       = t.pc;
        bus.mem_alu_result     = t.alu;
        bus.mem_data_read      = t.rdata;
        bus.mem_exception      = t.exc;
        bus.mem_exception_data = t.code;
        @(posedge clock);
        if (fl) begin
            slot       = '0;
            slot_valid = 1'b0;
        end else if (en) begin
            slot       = t;
            slot_valid = 1'b1;
            if (t.exc && t.code != 0 && cnt != 8'hFF) cnt = cnt + 8'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        slot       = '0;
        slot_valid = 1'b0;
        cnt        = 8'd0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(1'b1, 1'b0, rand_txn());
        cycle(1'b1, 1'b0, mk(r_insn(5'd3, 5'd0), 32'd1, 32'd7, 32'd0, 1'b1, 32'd1));
        slot = '0; slot_valid = 1'b0; cnt = 8'd0;
        n_checks++;
        if (dut_vec() !== 79'd0) $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_alu_write();
        cycle(1'b1, 1'b0, mk(r_insn(5'd3, 5'd0), 32'h10, 32'h0000_0007, 32'h5, 1'b0, 32'd0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd3, 32'h7})
            $display("FAIL add_write: got %b/%0d/%h expected 1/3/00000007",
                     bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec())
            $display("FAIL add_model: got %h expected %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_load_store();
        cycle(1'b1, 1'b0, mk(i_insn(5'b01000, 5'd5), 32'h20, 32'h100, 32'hDEAD_BEEF, 1'b0, 0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !==
            {1'b1, 5'd5, 32'hDEAD_BEEF})
            $display("FAIL lw_write: got %b/%0d/%h expected 1/5/deadbeef",
                     bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        else n_pass++;
        cycle(1'b1, 1'b0, mk(i_insn(5'b00111, 5'd5), 32'h21, 32'h104, 32'h1234, 1'b0, 0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== 38'd0)
            $display("FAIL sw_nowrite: got %b/%0d/%h expected 0/0/0",
                     bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        else n_pass++;
    endtask

    task automatic test_exceptions();
        do_reset();
        cycle(1'b1, 1'b0, mk(r_insn(5'd7, 5'd0), 32'h30, 32'h8000_0000, 0, 1'b1, 32'd1));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd30, 32'd1})
            $display("FAIL add_ovf: got %0d/%h expected 30/1", bus.ctrl_writeReg,
                     bus.data_writeReg);
        else n_pass++;
        cycle(1'b1, 1'b0, mk(i_insn(5'b00101, 5'd8), 32'h31, 32'h7FFF_FFFF, 0, 1'b1, 32'd2));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd30, 32'd2})
            $display("FAIL addi_ovf: got %0d/%h expected 30/2", bus.ctrl_writeReg,
                     bus.data_writeReg);
        else n_pass++;
        cycle(1'b1, 1'b0, mk(r_insn(5'd4, 5'b00010), 32'h32, 32'h0000_00A5, 0, 1'b1, 32'd0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd4, 32'hA5})
            $display("FAIL and_code0: got %0d/%h expected 4/a5", bus.ctrl_writeReg,
                     bus.data_writeReg);
        else n_pass++;
        n_checks++;
        if (bus.exception_count !== 8'd2)
            $display("FAIL exc_count: got %0d expected 2", bus.exception_count);
        else n_pass++;
    endtask

    task automatic test_jal_setx();
        cycle(1'b1, 1'b0, mk({5'b00011, 27'd100}, 32'h40, 32'h9, 32'h9, 1'b0, 0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd31, 32'h40})
            $display("FAIL jal_link: got %0d/%h expected 31/40", bus.ctrl_writeReg,
                     bus.data_writeReg);
        else n_pass++;
        cycle(1'b1, 1'b0, mk({5'b10101, 27'h7FF_FFFF}, 32'h41, 32'h9, 32'h9, 1'b0, 0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !==
            {1'b1, 5'd30, 32'h07FF_FFFF})
            $display("FAIL setx: got %0d/%h expected 30/07ffffff", bus.ctrl_writeReg,
                     bus.data_writeReg);
        else n_pass++;
        cycle(1'b1, 1'b0, mk(r_insn(5'd0, 5'd0), 32'h42, 32'h55, 32'h9, 1'b0, 0));
        n_checks++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== 38'd0)
            $display("FAIL r0_suppress: got %b/%0d/%h expected 0/0/0",
                     bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        else n_pass++;
    endtask

    task automatic test_stall_flush_reset();
        cycle(1'b1, 1'b0, mk(i_insn(5'b01000, 5'd6), 32'h50, 32'h200, 32'h12, 1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, rand_txn());
            n_checks++;
            if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !==
                {1'b1, 5'd6, 32'h12})
                $display("FAIL stall_hold%0d: got %0d/%h expected 6/12", i, bus.ctrl_writeReg,
                         bus.data_writeReg);
            else n_pass++;
        end
        cycle(1'b0, 1'b1, rand_txn());
        n_checks++;
        if ({bus.wb_valid, bus.wb_insn, bus.ctrl_writeEnable} !== 34'd0)
            $display("FAIL flush_bubble: got valid=%b insn=%h we=%b expected 0/0/0",
                     bus.wb_valid, bus.wb_insn, bus.ctrl_writeEnable);
        else n_pass++;
        cycle(1'b1, 1'b0, mk(r_insn(5'd9, 5'd0), 32'h60, 32'h99, 0, 1'b1, 32'd4));
        cycle(1'b0, 1'b0, rand_txn());
        #2;
        reset = 1'b0;
        slot = '0; slot_valid = 1'b0; cnt = 8'd0;
        #1;
        n_checks++;
        if (dut_vec() !== 79'd0)
            $display("FAIL async_reset: got %h expected 0", dut_vec());
        else n_pass++;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 1'b0, mk(r_insn(5'd2, 5'd1), 32'(i), 32'h8000_0000, 0, 1'b1, 32'd3));
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL sat_step%0d: got %h expected %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (bus.exception_count !== 8'd255)
            $display("FAIL sat_final: got %0d expected 255", bus.exception_count);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), rand_txn());
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL random%0d: got %h expected %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        slot     = '0;
        slot_valid = 1'b0;
        cnt      = 8'd0;
        bus.enable = 1'b0; bus.flush = 1'b0;
        bus.mem_insn = '0; bus.mem_pc_plus1 = '0; bus.mem_alu_result = '0;
        bus.mem_data_read = '0; bus.mem_exception = 1'b0; bus.mem_exception_data = '0;
        #1;
        test_reset();
        test_alu_write();
        test_load_store();
        test_exceptions();
        test_jal_setx();
        test_stall_flush_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
